// File: rtl/axis_write_data_if.sv
// Signal bundle for axis_write_data: config handshake, upstream word stream
// and the AXI write-data channel.
interface axis_write_data_if #(
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
);
  logic [CFG_DWIDTH-1:0]       cfg_length;
  logic                        cfg_val;
  logic                        cfg_rdy;
  logic [DATA_WIDTH-1:0]       data;
  logic                        valid;
  logic                        ready;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wlast;
  logic                        axi_wvalid;
  logic                        axi_wready;

  modport slave (
    input  cfg_length, cfg_val, data, valid, axi_wready,
    output cfg_rdy, ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid
  );

  modport master (
    output cfg_length, cfg_val, data, valid, axi_wready,
    input  cfg_rdy, ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid
  );
endinterface

// File: rtl/axis_write_data.sv
// Packs stream words into AXI write-data beats, one transfer per queued
// config length, with wlast at every burst boundary and at the final beat.
module axis_write_data #(
  parameter int BUF_CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_BEATS    = 16
) (
  input logic              clk,
  input logic              rst,
  axis_write_data_if.slave bus
);
  localparam int R     = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int LOG2R = $clog2(R);
  localparam int LW    = (R > 1) ? LOG2R : 1;
  localparam int SW    = DATA_WIDTH / 8;
  localparam int BW    = $clog2(BURST_BEATS + 1);
  localparam int DEPTH = 1 << BUF_CFG_AWIDTH;

  typedef enum logic [3:0] {
    CONFIG = 4'b0001,
    SET    = 4'b0010,
    ACTIVE = 4'b0100,
    DRAIN  = 4'b1000
  } state_t;

  state_t state_q, state_d;

  logic [CFG_DWIDTH-1:0]       fifo_mem_q [DEPTH];
  logic [BUF_CFG_AWIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BUF_CFG_AWIDTH:0]     count_q, count_d;
  logic [CFG_DWIDTH-1:0]       len_q, len_d;
  logic [CFG_DWIDTH-1:0]       word_rem_q, word_rem_d, beat_rem_q, beat_rem_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [BW-1:0]               burst_q, burst_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                        wvalid_q, wvalid_d, wlast_q, wlast_d;

  logic push, pop, fifo_empty, stream_ready;
  logic word_acc, beat_acc, last_word, beat_full;

  assign fifo_empty = (count_q == '0);
  assign push       = bus.cfg_val && bus.cfg_rdy;
  assign word_acc   = bus.valid && stream_ready;
  assign beat_acc   = wvalid_q && bus.axi_wready;
  assign last_word  = (word_rem_q == CFG_DWIDTH'(1));
  assign beat_full  = (int'(lane_q) == R - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CONFIG;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CONFIG:  if (!fifo_empty) state_d = SET;
      SET:     state_d = (len_q == '0) ? CONFIG : ACTIVE;
      ACTIVE:  if (word_acc && last_word) state_d = DRAIN;
      DRAIN:   if (beat_acc) state_d = CONFIG;
      default: state_d = CONFIG;
    endcase
  end

  // Upstream is stalled whenever a packed beat is waiting on the AXI side.
  always_comb begin
    pop            = (state_q == CONFIG) && !fifo_empty;
    stream_ready   = (state_q == ACTIVE) && (word_rem_q != '0) && !wvalid_q;
    bus.cfg_rdy    = (count_q != (BUF_CFG_AWIDTH+1)'(DEPTH));
    bus.ready      = stream_ready;
    bus.axi_wdata  = wdata_q;
    bus.axi_wstrb  = wstrb_q;
    bus.axi_wlast  = wlast_q;
    bus.axi_wvalid = wvalid_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.cfg_length;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + (BUF_CFG_AWIDTH+1)'(push) - (BUF_CFG_AWIDTH+1)'(pop);
    len_d      = len_q;
    word_rem_d = word_rem_q;
    beat_rem_d = beat_rem_q;
    lane_d     = lane_q;
    burst_d    = burst_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wvalid_d   = wvalid_q;
    wlast_d    = wlast_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      len_d    = fifo_mem_q[rd_ptr_q];
    end

    // Beat count is ceil(len / R); R is a power of two so this is a shift plus remainder test.
    if (state_q == SET) begin
      word_rem_d = len_q;
      beat_rem_d = (len_q >> LOG2R) + CFG_DWIDTH'(|(len_q & CFG_DWIDTH'(R - 1)));
      lane_d     = '0;
      burst_d    = '0;
    end

    if (beat_acc) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
      wdata_d  = '0;
      wstrb_d  = '0;
    end

    if (word_acc) begin
      wdata_d[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = bus.data;
      wstrb_d[int'(lane_q)*SW +: SW]                 = '1;
      word_rem_d = word_rem_q - CFG_DWIDTH'(1);
      if (beat_full || last_word) begin
        wvalid_d   = 1'b1;
        lane_d     = '0;
        beat_rem_d = beat_rem_q - CFG_DWIDTH'(1);
        if ((beat_rem_q == CFG_DWIDTH'(1)) || (burst_q == BW'(BURST_BEATS - 1))) begin
          wlast_d = 1'b1;
          burst_d = '0;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      len_q      <= '0;
      word_rem_q <= '0;
      beat_rem_q <= '0;
      lane_q     <= '0;
      burst_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      len_q      <= len_d;
      word_rem_q <= word_rem_d;
      beat_rem_q <= beat_rem_d;
      lane_q     <= lane_d;
      burst_q    <= burst_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
    end
  end
endmodule

// File: tb/tb_axis_write_data.sv
// Directed self-checking bench for axis_write_data with R=2, 16-beat bursts.
module tb_axis_write_data;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  beat_t beat_q[$];

  axis_write_data_if #(.CFG_DWIDTH(32), .AXI_DATA_WIDTH(64), .DATA_WIDTH(32)) bus ();

  axis_write_data #(
    .BUF_CFG_AWIDTH(5),
    .CFG_DWIDTH(32),
    .AXI_DATA_WIDTH(64),
    .DATA_WIDTH(32),
    .BURST_BEATS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beats are captured half a cycle before the edge that accepts them.
  always @(negedge clk) begin
    if (!rst && bus.axi_wvalid && bus.axi_wready)
      beat_q.push_back('{d: bus.axi_wdata, s: bus.axi_wstrb, l: bus.axi_wlast});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push_cfg(input logic [31:0] len);
    @(posedge clk); #1;
    bus.cfg_val    = 1'b1;
    bus.cfg_length = len;
    @(posedge clk); #1;
    bus.cfg_val    = 1'b0;
  endtask

  task automatic apply_stimulus(input int n, input int first);
    int w     = first;
    int sent  = 0;
    int guard = 0;
    bus.valid = 1'b1;
    bus.data  = 32'(w);
    while (sent < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (bus.ready) begin
        sent++;
        w++;
      end
      @(posedge clk); #1;
      bus.data = 32'(w);
    end
    bus.valid = 1'b0;
    check_output("words_sent", 64'(sent), 64'(n));
  endtask

  task automatic wait_beats(input string tag, input int n);
    int guard = 0;
    while (beat_q.size() < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_output({tag, "_count"}, 64'(beat_q.size()), 64'(n));
  endtask

  task automatic check_beat(input string tag, input logic [63:0] d, input logic [7:0] s, input logic l);
    beat_t b;
    check_output({tag, "_avail"}, 64'(beat_q.size() != 0), 64'(1));
    if (beat_q.size() != 0) begin
      b = beat_q.pop_front();
      check_output({tag, "_data"}, b.d, d);
      check_output({tag, "_strb"}, 64'(b.s), 64'(s));
      check_output({tag, "_last"}, 64'(b.l), 64'(l));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_wvalid"}, 64'(bus.axi_wvalid), 64'(0));
    check_output({tag, "_wlast"}, 64'(bus.axi_wlast), 64'(0));
    check_output({tag, "_wstrb"}, 64'(bus.axi_wstrb), 64'(0));
    check_output({tag, "_wdata"}, bus.axi_wdata, 64'(0));
    check_output({tag, "_ready"}, 64'(bus.ready), 64'(0));
    check_output({tag, "_cfg_rdy"}, 64'(bus.cfg_rdy), 64'(1));
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst            = 1'b1;
    bus.cfg_val    = 1'b0;
    bus.cfg_length = '0;
    bus.valid      = 1'b0;
    bus.data       = '0;
    bus.axi_wready = 1'b1;

    #23;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Full transfer of four words.
    push_cfg(32'd4);
    apply_stimulus(4, 1);
    wait_beats("len4", 2);
    check_beat("len4_b0", 64'h00000002_00000001, 8'hFF, 1'b0);
    check_beat("len4_b1", 64'h00000004_00000003, 8'hFF, 1'b1);

    // Odd length leaves the upper lane of the final beat empty.
    push_cfg(32'd3);
    apply_stimulus(3, 1);
    wait_beats("len3", 2);
    check_beat("len3_b0", 64'h00000002_00000001, 8'hFF, 1'b0);
    check_beat("len3_b1", 64'h00000000_00000003, 8'h0F, 1'b1);

    // Forty words span a full burst plus a four-beat tail.
    push_cfg(32'd40);
    apply_stimulus(40, 1);
    wait_beats("len40", 20);
    for (int i = 0; i < 20; i++) begin
      check_beat($sformatf("len40_b%0d", i),
                 {32'(2 * i + 2), 32'(2 * i + 1)}, 8'hFF, (i == 15) || (i == 19));
    end

    // Back-pressure on the first beat for ten cycles.
    bus.axi_wready = 1'b0;
    push_cfg(32'd8);
    apply_stimulus(2, 16);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output($sformatf("stall%0d_wvalid", i), 64'(bus.axi_wvalid), 64'(1));
      check_output($sformatf("stall%0d_wdata", i), bus.axi_wdata, 64'h00000011_00000010);
      check_output($sformatf("stall%0d_wstrb", i), 64'(bus.axi_wstrb), 64'hFF);
      check_output($sformatf("stall%0d_wlast", i), 64'(bus.axi_wlast), 64'(0));
      check_output($sformatf("stall%0d_ready", i), 64'(bus.ready), 64'(0));
    end
    @(posedge clk); #1;
    bus.axi_wready = 1'b1;
    apply_stimulus(6, 18);
    wait_beats("stall", 4);
    check_beat("stall_b0", 64'h00000011_00000010, 8'hFF, 1'b0);
    check_beat("stall_b1", 64'h00000013_00000012, 8'hFF, 1'b0);
    check_beat("stall_b2", 64'h00000015_00000014, 8'hFF, 1'b0);
    check_beat("stall_b3", 64'h00000017_00000016, 8'hFF, 1'b1);

    // Two queued configs must not merge words across transfers.
    push_cfg(32'd3);
    push_cfg(32'd2);
    apply_stimulus(5, 1);
    wait_beats("b2b", 3);
    check_beat("b2b_b0", 64'h00000002_00000001, 8'hFF, 1'b0);
    check_beat("b2b_b1", 64'h00000000_00000003, 8'h0F, 1'b1);
    check_beat("b2b_b2", 64'h00000005_00000004, 8'hFF, 1'b1);

    // A zero-length transfer produces no beat.
    push_cfg(32'd0);
    push_cfg(32'd2);
    apply_stimulus(2, 1);
    wait_beats("zero", 1);
    repeat (6) @(negedge clk);
    check_output("zero_extra_beats", 64'(beat_q.size()), 64'(1));
    check_beat("zero_b0", 64'h00000002_00000001, 8'hFF, 1'b1);
    beat_q.delete();

    // Reset while a beat is pending discards the transfer at once.
    bus.axi_wready = 1'b0;
    push_cfg(32'd6);
    apply_stimulus(2, 32);
    @(negedge clk);
    check_output("pre_rst_wvalid", 64'(bus.axi_wvalid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.axi_wready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_rst_no_beat", 64'(beat_q.size()), 64'(0));
    check_output("post_rst_wvalid", 64'(bus.axi_wvalid), 64'(0));

    push_cfg(32'd2);
    apply_stimulus(2, 7);
    wait_beats("recover", 1);
    check_beat("recover_b0", 64'h00000008_00000007, 8'hFF, 1'b1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axis_write_data.md
AXIS_WRITE_DATA -- requirements
Module: axis_write_data

Interface
REQ-001 Parameter BUF_CFG_AWIDTH, default 5, SHALL set the config FIFO depth to 2^BUF_CFG_AWIDTH entries.
REQ-002 Parameter CFG_DWIDTH, default 32, SHALL set the width of the transfer length (in stream words).
REQ-003 Parameter AXI_DATA_WIDTH, default 64, SHALL set the AXI write data width; it is an integer power-of-two multiple of DATA_WIDTH.
REQ-004 Parameter DATA_WIDTH, default 32, SHALL set the stream word width; R = AXI_DATA_WIDTH/DATA_WIDTH.
REQ-005 Parameter BURST_BEATS, default 16, SHALL set the maximum beats per AXI burst, matching the address-channel burst split.
REQ-006 Port clk, input, 1: single clock for all logic.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port cfg_length, input, CFG_DWIDTH: transfer length in stream words.
REQ-009 Port cfg_val / cfg_rdy, input / output, 1 each: config handshake.
REQ-010 Port data / valid / ready, input / input / output, DATA_WIDTH / 1 / 1: upstream stream handshake.
REQ-011 Port axi_wdata / axi_wstrb, output, AXI_DATA_WIDTH / AXI_DATA_WIDTH/8: AXI write data and byte strobes.
REQ-012 Port axi_wlast / axi_wvalid / axi_wready, output / output / input, 1 each: AXI write data channel handshake.

Function
REQ-013 Config FIFO SHALL push cfg_length on cfg_val & cfg_rdy; cfg_rdy = not full.
REQ-014 FSM SHALL be one-hot with states CONFIG, SET, ACTIVE, DRAIN.
REQ-015 CONFIG: when config FIFO non-empty, pop one entry -> SET; else stay.
REQ-016 SET: load word counter = popped length and beat counter = ceil(length/R); a length of 0 -> CONFIG with no AXI beat; else -> ACTIVE.
REQ-017 ACTIVE: ready = 1 only while words remain and the packer is not holding an un-accepted beat.
REQ-018 Packer SHALL place the first word of each beat in lane 0 (bits DATA_WIDTH-1:0), then ascending lanes.
REQ-019 A beat SHALL be presented (axi_wvalid=1) the cycle after its R-th word is accepted, or after the final word of the transfer is accepted.
REQ-020 For a partial final beat, unused lanes SHALL be zero and their strobe bits 0; all other beats have axi_wstrb all ones.
REQ-021 axi_wlast SHALL be 1 on every BURST_BEATS-th beat of a transfer and on the final beat; burst beat count restarts after each wlast.
REQ-022 While axi_wvalid=1 and axi_wready=0, axi_wdata, axi_wstrb and axi_wlast SHALL hold stable and ready SHALL be 0.
REQ-023 After the final word is accepted: ACTIVE -> DRAIN; DRAIN -> CONFIG on acceptance of the final beat.
REQ-024 Words of consecutive transfers SHALL never share a beat; each transfer starts at lane 0.
REQ-025 Counters SHALL be CFG_DWIDTH wide; length 2^CFG_DWIDTH-1 SHALL complete without wrap.
REQ-026 Throughput: with R=1 and axi_wready=1, one beat per two cycles minimum; no word is dropped or duplicated.

Reset
REQ-027 rst SHALL asynchronously clear the FSM to CONFIG, empty the config FIFO, and clear counters and packer.
REQ-028 During and after reset: axi_wvalid=0, axi_wlast=0, axi_wstrb=0, axi_wdata=0, ready=0, cfg_rdy=1 (FIFO empty).
REQ-029 Reset asserted mid-transfer SHALL drop axi_wvalid in the same cycle; the partial transfer is discarded.

Verification (R=2, BURST_BEATS=16)
REQ-030 cfg_length=4, words 1,2,3,4 -> beats 0x00000002_00000001 strb 0xFF wlast 0; 0x00000004_00000003 strb 0xFF wlast 1.
REQ-031 cfg_length=3, words 1,2,3 -> second beat 0x00000000_00000003 strb 0x0F wlast 1.
REQ-032 cfg_length=40 -> 20 beats; wlast=1 on beats 16 and 20 only.
REQ-033 axi_wready held 0 for 10 cycles mid-transfer -> beat stable, ready=0, all words delivered in order afterwards.
REQ-034 Configs 3 then 2 queued back-to-back -> beats {2,1},{0,3 strb 0x0F wlast},{5,4 wlast}; no cross-transfer merge.
REQ-035 cfg_length=0 followed by 2 -> only one beat {2,1} wlast 1; rst mid-transfer -> axi_wvalid=0 immediately, cfg_rdy=1.
